// File: rtl/eq_audio_pkg.sv
// Shared constants and helpers for the equalizer's codec-facing audio blocks.
// Frame geometry is fixed: 16-bit stereo samples, 1024 clk per frame, 32 clk per bit slot.
package eq_audio_pkg;

   localparam int FRAME_LEN = 1024;
   localparam int SLOT_LEN  = 32;
   localparam int LOAD_CNT  = 31;
   localparam int CNT_W     = 10;
   localparam int LRCLK_BIT = 9;
   localparam int SCLK_BIT  = 4;
   localparam int MCLK_BIT  = 1;
   localparam int SMPL_W    = 16;
   localparam int WORD_W    = 2 * SMPL_W;

   typedef struct packed {
      logic [SMPL_W-1:0] lft;
      logic [SMPL_W-1:0] rht;
   } stereo_t;

   // True on the last clk of a bit slot, i.e. the cycle before SCLK falls.
   function automatic logic slot_end(input logic [CNT_W-1:0] cnt);
      return (cnt[4:0] == 5'(SLOT_LEN - 1));
   endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter for codec-facing blocks: derives MCLK/SCLK/LRCLK
// directly from counter flops and decodes the load, shift and frame-start strobes.
module codec_clk_gen
   import eq_audio_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   output logic MCLK,
   output logic SCLK,
   output logic LRCLK,
   output logic load,
   output logic shift,
   output logic frame_start
);

   logic [CNT_W-1:0] cnt_r;
   logic             frame_start_r;
   logic             load_s;

   // Frame counter; 1024 is a power of two so the wrap to 0 is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 10'd0;
      end else begin
         cnt_r <= cnt_r + 10'd1;
      end
   end

   // Registered frame-start flag so it is high exactly while cnt == 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= (cnt_r == 10'(FRAME_LEN - 1));
      end
   end

   assign load_s      = (cnt_r == 10'(LOAD_CNT));
   assign load        = load_s;
   assign shift       = slot_end(cnt_r) && !load_s;
   assign frame_start = frame_start_r;

   assign MCLK  = cnt_r[MCLK_BIT];
   assign SCLK  = cnt_r[SCLK_BIT];
   assign LRCLK = cnt_r[LRCLK_BIT];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: double-buffers one stereo sample and serializes it MSB first
// with the standard one-bit delay, flagging underrun and overrun.
module i2s_tx
   import eq_audio_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SMPL_W-1:0] lft_smpl,
   input  logic [SMPL_W-1:0] rht_smpl,
   input  logic              smpl_vld,
   output logic              MCLK,
   output logic              SCLK,
   output logic              LRCLK,
   output logic              SDout,
   output logic              frame_req,
   output logic              underrun,
   output logic              overrun
);

   stereo_t           smpl_s;
   logic              load_s;
   logic              shift_s;
   logic [WORD_W-1:0] hold_r;
   logic [WORD_W-1:0] sr_r;
   logic              fresh_r;
   logic              underrun_r;
   logic              overrun_r;

   codec_clk_gen u_clk_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .MCLK        (MCLK),
      .SCLK        (SCLK),
      .LRCLK       (LRCLK),
      .load        (load_s),
      .shift       (shift_s),
      .frame_start (frame_req)
   );

   assign smpl_s.lft = lft_smpl;
   assign smpl_s.rht = rht_smpl;

   // Hold buffer, shift register and flags. A strobe landing on the load cycle
   // goes straight into the shift register; it is also kept so a later resend repeats it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r     <= 32'd0;
         sr_r       <= 32'd0;
         fresh_r    <= 1'b0;
         underrun_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         underrun_r <= 1'b0;
         overrun_r  <= 1'b0;
         if (load_s) begin
            sr_r       <= smpl_vld ? smpl_s : hold_r;
            fresh_r    <= 1'b0;
            underrun_r <= ~fresh_r & ~smpl_vld;
            if (smpl_vld) begin
               hold_r <= smpl_s;
            end else begin
               hold_r <= hold_r;
            end
         end else begin
            if (shift_s) begin
               sr_r <= {sr_r[WORD_W-2:0], 1'b0};
            end else begin
               sr_r <= sr_r;
            end
            if (smpl_vld) begin
               hold_r    <= smpl_s;
               fresh_r   <= 1'b1;
               overrun_r <= fresh_r;
            end else begin
               hold_r  <= hold_r;
               fresh_r <= fresh_r;
            end
         end
      end
   end

   assign SDout    = sr_r[WORD_W-1];
   assign underrun = underrun_r;
   assign overrun  = overrun_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level reference model pushes expected
// words at each load; a serial receiver pops and compares them as frames complete.
module tb_i2s_tx;

   logic        clk;
   logic        rst_n;
   logic [15:0] lft_smpl;
   logic [15:0] rht_smpl;
   logic        smpl_vld;
   logic        MCLK;
   logic        SCLK;
   logic        LRCLK;
   logic        SDout;
   logic        frame_req;
   logic        underrun;
   logic        overrun;

   i2s_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_smpl  (lft_smpl),
      .rht_smpl  (rht_smpl),
      .smpl_vld  (smpl_vld),
      .MCLK      (MCLK),
      .SCLK      (SCLK),
      .LRCLK     (LRCLK),
      .SDout     (SDout),
      .frame_req (frame_req),
      .underrun  (underrun),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   logic [9:0]  m_cnt;
   logic [31:0] m_hold;
   logic        m_fresh;
   logic [31:0] rx;
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h, expected %h (t=%0t, cnt=%0d)", tag, act, exp, $time, m_cnt);
      end
   endtask

   // One clk: drive inputs, advance the reference model at the edge, check #1 later.
   task automatic tick(input logic v, input logic [15:0] l, input logic [15:0] r);
      logic [9:0]  c;
      logic        e_under;
      logic        e_over;
      logic        e_fr;
      logic [31:0] word;
      smpl_vld = v;
      lft_smpl = l;
      rht_smpl = r;
      @(posedge clk);
      c       = m_cnt;
      e_under = (c == 10'd31) && !m_fresh && !v;
      e_over  = (c != 10'd31) && v && m_fresh;
      e_fr    = (c == 10'd1023);
      if (c == 10'd31) begin
         word = v ? {l, r} : m_hold;
         exp_q.push_back(word);
         if (v) m_hold = {l, r};
         m_fresh = 1'b0;
      end else if (v) begin
         m_hold  = {l, r};
         m_fresh = 1'b1;
      end
      m_cnt = c + 10'd1;
      #1;
      check_eq("pins", {26'd0, MCLK, SCLK, LRCLK, frame_req, underrun, overrun},
               {26'd0, m_cnt[1], m_cnt[4], m_cnt[9], e_fr, e_under, e_over});
      if (m_cnt[4:0] == 5'd16) begin
         rx = {rx[30:0], SDout};
         if (m_cnt[9:5] == 5'd0 && exp_q.size() > 0) begin
            word = exp_q.pop_front();
            check_eq("frame", rx, word);
         end
      end
      smpl_vld = 1'b0;
   endtask

   task automatic wait_cnt(input logic [9:0] target);
      int n;
      n = 0;
      while (m_cnt != target && n < 1100) begin
         tick(1'b0, 16'h0000, 16'h0000);
         n = n + 1;
      end
      check_eq("wait_cnt", {22'd0, m_cnt}, {22'd0, target});
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_eq("rst_async", {25'd0, MCLK, SCLK, LRCLK, SDout, frame_req, underrun, overrun}, 32'd0);
      m_cnt   = 10'd0;
      m_hold  = 32'd0;
      m_fresh = 1'b0;
      rx      = 32'd0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst_hold", {25'd0, MCLK, SCLK, LRCLK, SDout, frame_req, underrun, overrun}, 32'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      smpl_vld = 1'b0;
      lft_smpl = 16'h0000;
      rht_smpl = 16'h0000;
      rst_n    = 1'b0;
      m_cnt    = 10'd0;
      #2;
      apply_reset();

      // Idle for two frames: zeros on SDout, underrun once per frame.
      for (int i = 0; i < 2048; i++) tick(1'b0, 16'h0000, 16'h0000);

      wait_cnt(10'd10);
      tick(1'b1, 16'hA5C3, 16'h0F0F);
      wait_cnt(10'd0);

      // Two strobes before one load: overrun, newest wins.
      wait_cnt(10'd5);
      tick(1'b1, 16'h8000, 16'h0001);
      wait_cnt(10'd20);
      tick(1'b1, 16'h1234, 16'h5678);
      wait_cnt(10'd0);

      // Strobe exactly on the load cycle bypasses the hold buffer.
      wait_cnt(10'd31);
      tick(1'b1, 16'h7FFF, 16'h8000);
      wait_cnt(10'd0);

      // One sample, then starvation: the next frame repeats it.
      wait_cnt(10'd10);
      tick(1'b1, 16'h1111, 16'h2222);
      wait_cnt(10'd0);
      wait_cnt(10'd0);

      // Mid-frame reset, then a clean restart.
      wait_cnt(10'd500);
      apply_reset();
      wait_cnt(10'd10);
      tick(1'b1, 16'hCAFE, 16'hBEEF);
      wait_cnt(10'd0);
      wait_cnt(10'd0);
      wait_cnt(10'd40);

      check_eq("queue_drained", exp_q.size(), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
